ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit for the MIPS core: owns the PC register and issues fetches to instruction memory through a request/grant/response handshake.
- Presents the fetched word to decode with a valid/ready handshake.
- Consumes the next-PC value produced by the next-PC logic. It is the register end of that path: the next-PC logic computes the address, this block latches it and fetches from it.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; the first fetch address.
- ALIGN_CHECK, 1, 1 = misaligned npc raises fetch_err; 0 = npc[1:0] forced to 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- npc  in  32  next PC from next-PC logic; sampled only at the decode handshake.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  response instruction word.
- instr  out  32  held instruction to decode.
- pc  out  32  address of instr.
- pc8  out  32  pc+8, link address for jal/jalr.
- instr_valid  out  1  instr/pc valid for decode.
- instr_ready  in  1  decode accepts the instruction.
- fetch_err  out  1  sticky misaligned-PC error.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, state=REQ.
- After reset deasserts, the first rising edge has imem_req=1.
- State REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt=1 go to WAIT; otherwise stay in REQ, holding req and addr stable.
  - imem_rvalid is ignored in REQ.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid=1: instr<=imem_rdata, go to FULL. Otherwise stay in WAIT indefinitely.
- State FULL:
  - instr_valid=1; instr, pc and pc8 are held stable.
  - On instr_ready=1: pc<=npc, go to REQ.
  - On instr_ready=0: hold.
  - imem_rvalid is ignored in FULL.
- Latency: minimum 3 cycles per instruction (REQ with gnt, WAIT with rvalid, FULL with ready). Fetches are not pipelined; at most one request is outstanding.
- npc is sampled only on the FULL && instr_ready edge. Changes at any other time have no effect.
- Misaligned npc (ALIGN_CHECK=1, npc[1:0]!=0 at the handshake):
  - pc<=npc, fetch_err<=1, state goes to ERR.
  - ERR: imem_req=0, instr_valid=0. Cleared only by reset.
- ALIGN_CHECK=0: pc<={npc[31:2],2'b00}; fetch_err stays 0.
- pc8 = pc+8, combinational, modulo 2^32 (0xFFFF_FFFC+8 = 0x0000_0004).
- Reset during WAIT: the outstanding response is abandoned. Instruction memory shares the same reset and must drop its pending response.
- States encode in 2 bits. Any illegal encoding recovers to REQ on the next clock.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt[31:0], which increments on each FULL&&instr_ready handshake.
  - Adds output stall_cnt[31:0], which increments every cycle in REQ with imem_gnt=0, in WAIT with imem_rvalid=0, or in FULL with instr_ready=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, gnt=1 immediately, rvalid one cycle later with rdata=0x3C010001, ready=1 -> imem_addr=0x00003000, instr=0x3C010001, pc=0x3000, pc8=0x3008, instr_valid asserted on the third cycle after reset release.
- Sequential npc=pc+4 for 4 handshakes -> imem_addr sequence 0x3000, 0x3004, 0x3008, 0x300C; instr_valid is high exactly one cycle per instruction.
- gnt held low 3 cycles, then rvalid delayed 2 cycles, then ready low 2 cycles -> imem_addr stable during the gnt stall; instr/pc stable during the ready stall; stall_cnt=7 with IFU_PERF_CNT_EN.
- Jump: npc=0x00004000 presented only during the ready-low cycle, then 0x00003010 at handshake -> next imem_addr=0x3010.
- npc=0x00003002 at handshake (ALIGN_CHECK=1) -> fetch_err=1, imem_req stays 0, pc=0x3002; reset clears fetch_err and restores pc=0x3000.
- Assert reset during WAIT -> outputs return to reset values immediately; the first request after release uses addr 0x3000.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the MIPS core.
// Owns the PC register and fetches one instruction at a time from
// instruction memory over a req/gnt/rvalid handshake. It holds the fetched
// word for decode under a valid/ready handshake. At that handshake it
// latches the next PC from the next-PC logic.
// Optional build macro IFU_PERF_CNT_EN adds the fetch_cnt and stall_cnt
// performance counters.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc8,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_FULL = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   handshake;
    logic   npc_misaligned;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign handshake      = (state == S_FULL) && instr_ready;
    assign npc_misaligned = ALIGN_CHECK && (npc[1:0] != 2'b00);

    // The request is gated by reset so that nothing is issued while reset is asserted,
    // even though the state already sits in REQ.
    assign imem_req    = (state == S_REQ) && reset;
    assign imem_addr   = pc;
    assign instr_valid = (state == S_FULL);
    assign pc8         = pc + 32'd8;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one outstanding fetch. The ERR state is left only by reset.
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (imem_gnt) state_nxt = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_nxt = S_FULL;
            S_FULL:  if (instr_ready) state_nxt = npc_misaligned ? S_ERR : S_REQ;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_REQ;
        endcase
    end

    // PC, held instruction and sticky error. npc is looked at only on the decode handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            instr     <= 32'h0;
            fetch_err <= 1'b0;
        end else begin
            if ((state == S_WAIT) && imem_rvalid) begin
                instr <= imem_rdata;
            end
            if (handshake) begin
                if (npc_misaligned) begin
                    pc        <= npc;
                    fetch_err <= 1'b1;
                end else begin
                    pc <= align_word(npc);
                end
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic stall_now;

    assign stall_now = ((state == S_REQ)  && !imem_gnt)    ||
                       ((state == S_WAIT) && !imem_rvalid) ||
                       ((state == S_FULL) && !instr_ready);

    // Performance counters: completed handshakes and stalled cycles. Both wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (handshake) fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_now) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch.
// The driver plays both instruction memory and decode. It follows the fetch
// protocol at transaction level and pushes the expected {pc, instr} into a
// queue. A negedge monitor compares the DUT outputs against that expectation.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    localparam int P_RST  = 0;
    localparam int P_REQ  = 1;
    localparam int P_WAIT = 2;
    localparam int P_FULL = 3;
    localparam int P_ERR  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        fetch_err;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    exp_t        sb_q[$];
    int          phase = P_RST;
    logic [31:0] exp_pc = RESET_PC;
    logic        exp_err = 1'b0;
    logic [31:0] exp_stall = 32'h0;
    logic [31:0] exp_fetch = 32'h0;
    int          checks = 0;
    int          errors = 0;

    ifu_fetch #(.RESET_PC(RESET_PC), .ALIGN_CHECK(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .pc8        (pc8),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_err  (fetch_err)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic rbit();
        int unsigned r;
        r = $urandom;
        return r[0];
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Asynchronous reset: the outputs must drop at once. Release happens after two clock edges.
    task automatic do_reset();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        reset       = 1'b0;
        phase       = P_RST;
        exp_pc      = RESET_PC;
        exp_err     = 1'b0;
        exp_stall   = 32'h0;
        exp_fetch   = 32'h0;
        sb_q.delete();
        #1;
        check1("rst_imem_req", imem_req, 1'b0);
        check1("rst_instr_valid", instr_valid, 1'b0);
        check1("rst_fetch_err", fetch_err, 1'b0);
        check32("rst_pc", pc, RESET_PC);
        check32("rst_instr", instr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        phase = P_REQ;
    endtask

    // One instruction: gd cycles without grant, rd cycles without response and yd cycles
    // without ready. Inputs that the current state should ignore are randomised.
    task automatic do_instr(input int gd, input int rd, input int yd, input logic [31:0] word,
                            input logic [31:0] nxt, input logic [31:0] stall_npc);
        sb_q.push_back('{pc: exp_pc, instr: word});
        for (int i = 0; i <= gd; i++) begin
            imem_gnt    = (i == gd);
            imem_rvalid = rbit();
            imem_rdata  = $urandom;
            instr_ready = rbit();
            npc         = $urandom;
            @(posedge clk);
            #1;
            if (i < gd) exp_stall++;
        end
        phase    = P_WAIT;
        imem_gnt = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            imem_rvalid = (i == rd);
            imem_rdata  = (i == rd) ? word : $urandom;
            instr_ready = rbit();
            npc         = $urandom;
            @(posedge clk);
            #1;
            if (i < rd) exp_stall++;
        end
        phase = P_FULL;
        for (int i = 0; i <= yd; i++) begin
            instr_ready = (i == yd);
            npc         = (i == yd) ? nxt : stall_npc;
            imem_rvalid = rbit();
            imem_rdata  = $urandom;
            @(posedge clk);
            #1;
            if (i < yd) exp_stall++;
        end
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        exp_fetch++;
        if (nxt[1:0] != 2'b00) begin
            exp_pc  = nxt;
            exp_err = 1'b1;
            phase   = P_ERR;
        end else begin
            exp_pc = nxt;
            phase  = P_REQ;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            imem_gnt    = rbit();
            imem_rvalid = rbit();
            instr_ready = rbit();
            npc         = $urandom;
            @(posedge clk);
            #1;
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
    endtask

    // Monitor: compare every output against the expected protocol state, once per cycle on the
    // falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check1("imem_req", imem_req, phase == P_REQ);
            check1("instr_valid", instr_valid, phase == P_FULL);
            check1("fetch_err", fetch_err, exp_err);
            check32("pc", pc, exp_pc);
            check32("pc8", pc8, exp_pc + 32'd8);
            if (phase == P_REQ) check32("imem_addr", imem_addr, exp_pc);
            if (phase == P_RST) check32("instr_in_reset", instr, 32'h0);
            if (instr_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=valid expected=no_instruction t=%0t", $time);
                end else begin
                    check32("instr", instr, sb_q[0].instr);
                    check32("instr_pc", pc, sb_q[0].pc);
                    if (instr_ready) void'(sb_q.pop_front());
                end
            end
`ifdef IFU_PERF_CNT_EN
            check32("fetch_cnt", fetch_cnt, exp_fetch);
            check32("stall_cnt", stall_cnt, exp_stall);
`endif
        end
    end

    initial begin
        logic [31:0] nxt;
        int unsigned r;
        reset = 1'b1;
        #1;
        do_reset();

        // First fetch from RESET_PC, followed by a sequential run.
        do_instr(0, 0, 0, 32'h3C01_0001, 32'h0000_3004, 32'h0);
        do_instr(0, 0, 0, 32'h2421_0004, 32'h0000_3008, 32'h0);
        do_instr(0, 0, 0, 32'h0000_0000, 32'h0000_300C, 32'h0);
        do_instr(0, 0, 0, 32'hAC01_0000, 32'h0000_3010, 32'h0);

        // Stalls in all three phases.
        do_reset();
        do_instr(3, 2, 2, 32'h1234_5678, 32'h0000_3004, 32'h0000_4000);
`ifdef IFU_PERF_CNT_EN
        check32("stall_cnt_seven", stall_cnt, 32'd7);
`endif

        // A jump target shown only while ready is low must be ignored.
        do_instr(0, 0, 2, 32'h0800_0C04, 32'h0000_3010, 32'h0000_4000);
        do_instr(0, 1, 0, 32'h0000_0008, 32'h0000_3014, 32'h0);

        // Misaligned next PC.
        do_instr(1, 0, 1, 32'h0000_000C, 32'h0000_3002, 32'h0000_5000);
        idle(4);
        check32("err_pc", pc, 32'h0000_3002);
        check1("err_req", imem_req, 1'b0);
        check1("err_flag", fetch_err, 1'b1);
        do_reset();
        check32("pc_after_err_reset", pc, RESET_PC);

        // Reset while a response is outstanding.
        imem_gnt = 1'b1;
        @(posedge clk);
        #1;
        imem_gnt = 1'b0;
        phase    = P_WAIT;
        @(posedge clk);
        #1;
        do_reset();
        check32("addr_after_wait_reset", imem_addr, 32'h0000_3000);
        do_instr(0, 0, 0, 32'h2000_0001, 32'h0000_3004, 32'h0);

        // Randomised traffic, including jumps, PC wrap and misaligned targets.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      nxt = exp_pc + 32'd4;
            else if (r < 88) nxt = $urandom & 32'hFFFF_FFFC;
            else if (r < 94) nxt = 32'hFFFF_FFFC;
            else             nxt = ($urandom & 32'hFFFF_FFFC) | $urandom_range(1, 3);
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom, nxt, $urandom);
            if (phase == P_ERR) begin
                idle(3);
                do_reset();
            end
        end

        @(negedge clk);
        check32("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
